// File: rtl/updown_cmd_if.sv
// Button-side and counter-side signals of the up/down command front end.
// The master drives the buttons and load value; the slave issues commands.
interface updown_cmd_if #(
  parameter int W = 4
);
  logic         btn_up;
  logic         btn_down;
  logic         btn_load;
  logic [W-1:0] ld_val;
  logic         en;
  logic         up;
  logic         down;
  logic [W-1:0] ld;
  logic         busy;

  modport master (
    output btn_up, btn_down, btn_load, ld_val,
    input  en, up, down, ld, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_load, ld_val,
    output en, up, down, ld, busy
  );
endinterface

// File: rtl/updown_cmd_ctrl.sv
// Push-button front end: sync, debounce, edge detect and auto-repeat,
// then one prioritised, one-cycle command per clock to the counter.
module updown_cmd_ctrl #(
  parameter int W          = 4,
  parameter int DB_CYCLES  = 4,
  parameter int RPT_CYCLES = 16
) (
  input logic        clk,
  input logic        rst,
  updown_cmd_if.slave bus
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int RW = (RPT_CYCLES > 1) ? $clog2(RPT_CYCLES) : 1;

  // Button index: 0 = load, 1 = up, 2 = down
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s;
  logic [2:0]    db;
  logic [2:0]    dbq;
  logic [2:0]    rise;
  logic [2:0]    rpt;
  logic [2:0]    pend;
  logic [2:0]    iss;
  logic [DW-1:0] dc [3];
  logic [RW-1:0] rc [2];
  logic [W-1:0]  shadow;
  logic [W-1:0]  ld_r;
  logic          en_r;
  logic          up_r;
  logic          dn_r;

  assign raw  = {bus.btn_down, bus.btn_up, bus.btn_load};
  assign rise = db & ~dbq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s   <= '0;
      db  <= '0;
      dbq <= '0;
      for (int i = 0; i < 3; i++) dc[i] <= '0;
    end else begin
      s1  <= raw;
      s   <= s1;
      dbq <= db;
      for (int i = 0; i < 3; i++) begin
        if (s[i] == db[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DW'(DB_CYCLES - 1)) begin
          db[i] <= s[i];
          dc[i] <= '0;
        end else begin
          dc[i] <= dc[i] + 1'b1;
        end
      end
    end
  end

  // Repeat counters restart on the press edge and after each repeat
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) rc[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!db[j+1] || rise[j+1]) begin
          rc[j] <= '0;
        end else if (rc[j] == RW'(RPT_CYCLES - 1)) begin
          rc[j] <= '0;
        end else begin
          rc[j] <= rc[j] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rpt = '0;
    for (int j = 0; j < 2; j++) begin
      rpt[j+1] = (RPT_CYCLES > 0) && db[j+1] && !rise[j+1]
               && (rc[j] == RW'(RPT_CYCLES - 1));
    end
  end

  always_comb begin
    iss = '0;
    priority case (1'b1)
      pend[0]: iss = 3'b001;
      pend[1]: iss = 3'b010;
      pend[2]: iss = 3'b100;
      default: iss = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      shadow <= '0;
      ld_r   <= '0;
      en_r   <= 1'b0;
      up_r   <= 1'b0;
      dn_r   <= 1'b0;
    end else begin
      pend <= (pend & ~iss) | rise | rpt;
      en_r <= iss[0];
      up_r <= iss[1];
      dn_r <= iss[2];
      if (rise[0]) shadow <= bus.ld_val;
      if (iss[0])  ld_r   <= shadow;
    end
  end

  assign bus.en   = en_r;
  assign bus.up   = up_r;
  assign bus.down = dn_r;
  assign bus.ld   = ld_r;
  assign bus.busy = |pend;
endmodule

// File: tb/tb_updown_cmd_ctrl.sv
// Scoreboard bench for updown_cmd_ctrl with DB_CYCLES=4, RPT_CYCLES=16.
// Expected pulses are queued at stimulus time and matched by a monitor.
module tb_updown_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_on = 1'b0;
  int   t0;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [3:0] ld;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  updown_cmd_if #(.W(4)) bus ();

  updown_cmd_ctrl #(
    .W(4),
    .DB_CYCLES(4),
    .RPT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, want,
               edge_n);
    end
  endtask

  task automatic go(input int n);
    while (edge_n < n) @(negedge clk);
    #2;
  endtask

  task automatic push(input int cyc, input logic [2:0] cmd,
                      input logic [3:0] ldv);
    exp_t x;
    x.cyc = cyc;
    x.cmd = cmd;
    x.ld  = ldv;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("excl", 32'($countones({bus.en, bus.up, bus.down}) <= 1), 1);
      if (bus.en || bus.up || bus.down) begin
        if (sbq.size() == 0) begin
          chk("spurious", {bus.en, bus.up, bus.down}, 0);
        end else begin
          e = sbq.pop_front();
          chk("when", edge_n, e.cyc);
          chk("cmd", {bus.en, bus.up, bus.down}, e.cmd);
          if (e.cmd[2]) chk("ld", bus.ld, e.ld);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] bounce;
    bounce = 5'b10110;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_load = 1'b0;
    bus.ld_val   = 4'b1010;

    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", {bus.en, bus.up, bus.down, bus.busy, bus.ld}, 0);
    end
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rel_out", {bus.en, bus.up, bus.down, bus.busy, bus.ld}, 0);
    end
    #2;

    // held up: first pulse plus two repeats
    bus.btn_up = 1'b1;
    t0 = edge_n + 1;
    push(t0 + 7,  3'b010, 4'h0);
    push(t0 + 23, 3'b010, 4'h0);
    push(t0 + 39, 3'b010, 4'h0);
    go(t0 + 39);
    bus.btn_up = 1'b0;
    go(t0 + 75);
    chk("drain_up", sbq.size(), 0);

    // bouncing down, then stable
    for (int i = 4; i >= 0; i--) begin
      bus.btn_down = bounce[i];
      go(edge_n + 1);
    end
    bus.btn_down = 1'b1;
    t0 = edge_n + 1;
    push(t0 + 7, 3'b001, 4'h0);
    go(t0 + 10);
    bus.btn_down = 1'b0;
    go(t0 + 30);
    chk("drain_dn", sbq.size(), 0);

    // load value changes while load is pending
    bus.ld_val   = 4'b1010;
    bus.btn_load = 1'b1;
    t0 = edge_n + 1;
    push(t0 + 7, 3'b100, 4'b1010);
    go(t0 + 6);
    bus.ld_val = 4'b0101;
    go(t0 + 8);
    chk("ld_hold", bus.ld, 4'b1010);
    bus.btn_load = 1'b0;
    go(t0 + 20);
    chk("ld_hold2", bus.ld, 4'b1010);
    chk("drain_ld", sbq.size(), 0);

    // all three at once
    bus.ld_val   = 4'b0011;
    bus.btn_load = 1'b1;
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    t0 = edge_n + 1;
    push(t0 + 7, 3'b100, 4'b0011);
    push(t0 + 8, 3'b010, 4'h0);
    push(t0 + 9, 3'b001, 4'h0);
    go(t0 + 5);
    chk("busy_pre", bus.busy, 0);
    go(t0 + 6);
    chk("busy_6", bus.busy, 1);
    go(t0 + 7);
    chk("busy_7", bus.busy, 1);
    go(t0 + 8);
    chk("busy_8", bus.busy, 1);
    go(t0 + 10);
    bus.btn_load = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    go(t0 + 12);
    chk("busy_end", bus.busy, 0);
    go(t0 + 35);
    chk("drain_all", sbq.size(), 0);

    // reset one cycle before the up pulse is due
    bus.btn_up = 1'b1;
    t0 = edge_n + 1;
    go(t0 + 5);
    rst = 1'b1;
    go(t0 + 6);
    rst = 1'b0;
    chk("rst_up", bus.up, 0);
    chk("rst_busy", bus.busy, 0);
    push(t0 + 14, 3'b010, 4'h0);
    go(t0 + 7);
    chk("rst_noup", bus.up, 0);
    go(t0 + 20);
    bus.btn_up = 1'b0;
    go(t0 + 45);
    chk("drain_rst", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
